// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the tx and rx stages.
package uart_pkg;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit and hands bytes out on valid/ready.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | timing half a bit to confirm the start bit at its centre
// DATA      | sampling 8 data bits, LSB first
// STOP      | waiting for the stop-bit centre
// WAIT_IDLE | framing error seen; hold until the line returns high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t              state_q, state_d;
    logic                   din_s;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_idx_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   deliver_q;
    logic                   half_tc, full_tc;
    logic                   cnt_clr, shift_en, stop_ok, stop_bad;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    assign half_tc = (cnt_q == HALF_TC);
    assign full_tc = (cnt_q == FULL_TC);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!din_s) state_d = START;
            START:     if (half_tc) state_d = din_s ? IDLE : DATA;
            DATA:      if (full_tc && bit_idx_q == LAST_BIT) state_d = STOP;
            STOP:      if (full_tc) state_d = din_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (din_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b1;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            START: cnt_clr = half_tc;
            DATA: begin
                cnt_clr  = full_tc;
                shift_en = full_tc;
            end
            STOP: begin
                cnt_clr  = full_tc;
                stop_ok  = full_tc && din_s;
                stop_bad = full_tc && !din_s;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            deliver_q <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;

            if (state_q != DATA) bit_idx_q <= '0;
            else if (shift_en)   bit_idx_q <= bit_idx_q + 1'b1;

            if (shift_en) shreg_q <= {din_s, shreg_q[DATA_BITS-1:1]};

            deliver_q <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= 1'b0;

            // An accept in the delivery cycle frees the slot, so the new byte takes it.
            if (deliver_q) begin
                if (!valid || ready) begin
                    data  <= shreg_q;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus corner-case sequences, scoreboarded.
module tb_uart_rx;
    localparam int CPB = 16;

    typedef struct {
        logic [7:0] b;
        logic       stop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, din, ready;
    logic [7:0] data;
    logic       valid, frame_err, overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0, n_ferr = 0, n_ovr = 0, n_vcyc = 0, n_both = 0;
    int t_valid = 0;
    logic valid_d = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        din = 1'b0;
        repeat (CPB) wait_clk();
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (CPB) wait_clk();
        end
        din = stop;
        repeat (CPB) wait_clk();
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            logic [8:0] e;
            if (valid) n_vcyc++;
            if (valid && !valid_d) t_valid = cyc;
            valid_d = valid;
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (frame_err && overrun) n_both++;
            if (valid && ready) begin
                n_acc++;
                e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h1FF;
                check("rx_data", {23'd0, 1'b0, data}, {23'd0, e});
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   a0, f0, o0, v0, t0, lat;

        vecs[0] = '{8'h6C, 1'b1};
        vecs[1] = '{8'hFF, 1'b1};
        vecs[2] = '{8'h00, 1'b1};
        vecs[3] = '{8'hA5, 1'b1};
        vecs[4] = '{8'h3C, 1'b1};
        vecs[5] = '{8'h81, 1'b1};

        rst = 1'b1; din = 1'b1; ready = 1'b1;
        repeat (3) wait_clk();
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        repeat (5) wait_clk();

        // back-to-back frames with ready held high
        for (int i = 0; i < 6; i++) begin
            a0 = n_acc; v0 = n_vcyc; f0 = n_ferr;
            t0 = cyc;
            if (vecs[i].stop) exp_q.push_back(vecs[i].b);
            send_frame(vecs[i].b, vecs[i].stop);
            check("vec_accept", n_acc - a0, 1);
            check("vec_valid_cycles", n_vcyc - v0, 1);
            check("vec_no_ferr", n_ferr - f0, 0);
            if (i == 0) begin
                lat = t_valid - t0;
                check("latency_in_window", (lat >= 154 && lat <= 157), 1);
            end
        end
        repeat (10) wait_clk();

        // short glitch is rejected
        a0 = n_acc; f0 = n_ferr;
        din = 1'b0;
        repeat (4) wait_clk();
        din = 1'b1;
        repeat (40) wait_clk();
        check("glitch_no_valid", n_acc - a0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("post_glitch_accept", n_acc - a0, 1);
        repeat (10) wait_clk();

        // framing error, then line held low
        a0 = n_acc; f0 = n_ferr;
        send_frame(8'h55, 1'b0);
        repeat (40) wait_clk();
        din = 1'b1;
        repeat (20) wait_clk();
        check("ferr_pulses", n_ferr - f0, 1);
        check("ferr_no_valid", n_acc - a0, 0);
        check("ferr_valid_low", valid, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("post_ferr_accept", n_acc - a0, 1);
        check("post_ferr_no_ferr", n_ferr - f0, 1);
        repeat (10) wait_clk();

        // overrun with consumer stalled
        ready = 1'b0;
        a0 = n_acc; o0 = n_ovr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) wait_clk();
        check("ovr_valid_held", valid, 1);
        check("ovr_data_held", data, 8'h11);
        check("ovr_pulses", n_ovr - o0, 1);
        ready = 1'b1;
        wait_clk();
        ready = 1'b0;
        wait_clk();
        check("ovr_valid_dropped", valid, 0);
        check("ovr_one_accept", n_acc - a0, 1);
        ready = 1'b1;
        repeat (10) wait_clk();

        // reset mid-frame
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        din = 1'b0;
        repeat (CPB) wait_clk();
        for (int i = 0; i < 3; i++) begin
            din = (8'h5A >> i) & 8'h01;
            repeat (CPB) wait_clk();
        end
        rst = 1'b1; din = 1'b1;
        wait_clk();
        rst = 1'b0;
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_ovr", overrun, 0);
        repeat (200) wait_clk();
        check("midrst_no_valid", n_acc - a0, 0);
        check("midrst_no_ferr", n_ferr - f0, 0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("post_rst_accept", n_acc - a0, 1);
        check("post_rst_no_ovr", n_ovr - o0, 0);

        for (int k = 0; k < 500 && exp_q.size() != 0; k++) wait_clk();
        check("scoreboard_empty", exp_q.size(), 0);
        check("ferr_ovr_exclusive", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
